// File: rtl/swap_sched_if.sv
`default_nettype none
// swap_sched_if: request/status bundle between the system side, the scheduler and the swap unit (rev 1.0).
interface swap_sched_if #(
  parameter int CNT_W = 3
);
  logic             req;
  logic             req_ack;
  logic             w;
  logic             done;
  logic             clr_err;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             timeout_err;
  logic [7:0]       swaps_done;

  modport master (
    output req, done, clr_err,
    input  req_ack, w, busy, pending, timeout_err, swaps_done
  );

  modport slave (
    input  req, done, clr_err,
    output req_ack, w, busy, pending, timeout_err, swaps_done
  );
endinterface
`default_nettype wire

// File: rtl/swap_sched.sv
`default_nettype none
// swap_sched: queues swap requests and issues them one at a time to the bus swap unit (rev 1.0).
// Completed-swap counter is built only when SWAP_SCHED_STATS_EN is defined; otherwise swaps_done is 0.
module swap_sched #(
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT     = 15,
  parameter int TO_W        = 4
) (
  input  logic        ck,
  input  logic        rst,
  swap_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);
  localparam logic [TO_W-1:0]  WD_LAST  = TO_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] pending_base;
  logic [TO_W-1:0]  wd;
  logic             w_q;
  logic             err_q;
  logic             issue;
  logic             accept;
  logic             complete;
  logic             expire;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Completion is checked before the watchdog so a done on the expiry cycle still counts.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          issue      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.done) begin
          complete   = 1'b1;
          state_next = GAP;
        end else if (wd == WD_LAST) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Room is judged after this cycle's issue, so a full queue can still accept while issuing.
  assign pending_base = pending - CNT_W'(issue);
  assign accept       = bus.req && (pending_base < PEND_MAX);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      pending <= '0;
      wd      <= '0;
      w_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pending <= pending_base + CNT_W'(accept);
      w_q     <= (state_next == ISSUE);
      if (state == ISSUE) begin
        wd <= '0;
      end else if (state == WAIT) begin
        wd <= wd + TO_W'(1);
      end
      if (expire) begin
        err_q <= 1'b1;
      end else if (bus.clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

`ifdef SWAP_SCHED_STATS_EN
  logic [7:0] swaps_q;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      swaps_q <= 8'd0;
    end else if (complete) begin
      swaps_q <= swaps_q + 8'd1;
    end
  end

  assign bus.swaps_done = swaps_q;
`else
  logic unused_complete;
  assign unused_complete = complete;
  assign bus.swaps_done  = 8'd0;
`endif

  assign bus.req_ack     = accept;
  assign bus.w           = w_q;
  assign bus.busy        = (state != IDLE);
  assign bus.pending     = pending;
  assign bus.timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_swap_sched.sv
`default_nettype none
// tb_swap_sched: directed and random stimulus against a job-timeline reference model of swap_sched.
module tb_swap_sched;
  localparam int MAX_PENDING = 7;
  localparam int CNT_W       = 3;
  localparam int TIMEOUT     = 15;
  localparam int TO_W        = 4;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  swap_sched_if #(.CNT_W(CNT_W)) bus ();

  swap_sched #(
    .MAX_PENDING(MAX_PENDING),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .TO_W       (TO_W)
  ) dut (
    .ck (ck),
    .rst(rst),
    .bus(bus)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: one job in flight, described by the cycle its w pulse appears and the cycle done was taken.
  int m_pend;
  bit m_job;
  int m_start;
  int m_done_at;
  bit m_err;
  int m_swaps;

  int done_lat  = 1000;
  bit rnd_done  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend    = 0;
    m_job     = 1'b0;
    m_start   = 0;
    m_done_at = -1;
    m_err     = 1'b0;
    m_swaps   = 0;
  endtask

  task automatic check_and_advance();
    bit issue_now;
    bit in_wait;
    bit e_ack;
    bit expire;
    int base;
    int e_sw;
    issue_now = !m_job && (m_pend > 0);
    in_wait   = m_job && (cyc > m_start) && (m_done_at < 0);
    base      = m_pend - (issue_now ? 1 : 0);
    e_ack     = bus.req && (base < MAX_PENDING);
`ifdef SWAP_SCHED_STATS_EN
    e_sw = m_swaps;
`else
    e_sw = 0;
`endif
    chk("req_ack",     32'(bus.req_ack),     32'(e_ack));
    chk("w",           32'(bus.w),           32'(m_job && (cyc == m_start)));
    chk("busy",        32'(bus.busy),        32'(m_job && (cyc >= m_start)));
    chk("pending",     32'(bus.pending),     32'(m_pend));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    chk("swaps_done",  32'(bus.swaps_done),  32'(e_sw));
    if (!rst) begin
      expire = 1'b0;
      if (issue_now) begin
        m_job     = 1'b1;
        m_start   = cyc + 1;
        m_done_at = -1;
      end else if (in_wait) begin
        if (bus.done) begin
          m_done_at = cyc;
          m_swaps   = (m_swaps + 1) % 256;
        end else if (cyc - (m_start + 1) == TIMEOUT - 1) begin
          m_job  = 1'b0;
          expire = 1'b1;
        end
      end else if (m_job && (m_done_at >= 0) && (cyc == m_done_at + 1)) begin
        m_job = 1'b0;
      end
      if (expire) m_err = 1'b1;
      else if (bus.clr_err) m_err = 1'b0;
      m_pend = base + (e_ack ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(negedge ck);
    check_and_advance();
    @(posedge ck);
    #1;
    cyc++;
  endtask

  task automatic step();
    if (rnd_done) bus.done = ($urandom_range(5) == 0);
    else          bus.done = m_job && (cyc == m_start + done_lat);
    tick();
  endtask

  task automatic pulse_req();
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
  endtask

  initial begin
    bus.req     = 1'b0;
    bus.done    = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    rst = 1'b0;

    // Single request, swap unit answers 4 cycles after w
    repeat (3) step();
    done_lat = 4;
    pulse_req();
    repeat (12) step();

    // Spurious done while idle
    bus.done = 1'b1;
    repeat (3) tick();
    bus.done = 1'b0;

    // Fill to full with done stalled, then drain
    done_lat = 1000;
    bus.req  = 1'b1;
    repeat (9) step();
    bus.req  = 1'b0;
    done_lat = 4;
    repeat (90) step();

    // Timeout, then clear
    done_lat = 1000;
    pulse_req();
    repeat (24) step();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    repeat (2) step();

    // Timeout while clr_err held: set wins
    bus.clr_err = 1'b1;
    pulse_req();
    repeat (22) step();
    bus.clr_err = 1'b0;
    repeat (2) step();

    // done on the watchdog expiry cycle
    done_lat = TIMEOUT;
    pulse_req();
    repeat (25) step();

    // Random traffic with random done pulses
    rnd_done = 1'b1;
    repeat (2000) begin
      bus.req     = ($urandom_range(2) == 0);
      bus.clr_err = ($urandom_range(15) == 0);
      step();
    end
    rnd_done = 1'b0;

    // Random traffic with scheduled done latencies, some beyond the watchdog
    repeat (40) begin
      done_lat = $urandom_range(2, 18);
      repeat (40) begin
        bus.req     = ($urandom_range(3) == 0);
        bus.clr_err = ($urandom_range(15) == 0);
        step();
      end
    end
    bus.req     = 1'b0;
    bus.clr_err = 1'b0;
    done_lat    = 3;
    repeat (100) step();

    // Async reset in WAIT with three requests queued
    done_lat = 1000;
    bus.req  = 1'b1;
    repeat (4) step();
    bus.req  = 1'b0;
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_w",       32'(bus.w),           32'd0);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_pending", 32'(bus.pending),     32'd0);
    chk("rst_err",     32'(bus.timeout_err), 32'd0);
    chk("rst_swaps",   32'(bus.swaps_done),  32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) step();
    pulse_req();
    done_lat = 2;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swap_sched.md
Name: swap_sched

Overview:
- Request scheduler placed directly upstream of the 3-register bus swap unit.
- Accepts single-cycle swap requests from the system side and queues them in a pending counter.
- Issues them one at a time on the swap unit's `w` input and waits for its `done`.
- Also provides: a watchdog timeout, busy/pending status, and an optional completed-swap counter.

Parameters:
- MAX_PENDING, 7, maximum queued requests not yet issued (1..2**CNT_W-1).
- CNT_W, 3, width of the pending counter.
- TIMEOUT, 15, cycles allowed in WAIT for `done` before abort (>=2).
- TO_W, 4, width of the watchdog counter (must hold TIMEOUT).

Ports:
- ck  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  1  swap request pulse; one request per high cycle.
- req_ack  out  1  combinational; high when `req` is accepted this cycle.
- w  out  1  to swap unit; one-cycle start pulse.
- done  in  1  from swap unit; one-cycle completion pulse.
- clr_err  in  1  synchronous clear of `timeout_err`.
- busy  out  1  high in ISSUE, WAIT, GAP.
- pending  out  CNT_W  queued requests not yet issued.
- timeout_err  out  1  sticky; set on watchdog expiry.
- swaps_done  out  8  completed swaps, wraps 255->0 (see optional feature).

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; pending = 0; watchdog = 0.
  - w = 0, busy = 0, timeout_err = 0, swaps_done = 0.
  - rst asserted mid-swap abandons the swap silently; no `w` is re-issued.
- Acceptance:
  - req_ack = req && (pending_next_base < MAX_PENDING), where pending_next_base is `pending` after any same-cycle issue decrement.
  - When full, `req` is dropped and req_ack = 0.
- Pending update per cycle: pending + accept − issue.
  - Simultaneous accept and issue leaves pending unchanged.
  - Never exceeds MAX_PENDING; never underflows.
- w is a registered output, high exactly one cycle, in ISSUE only.
- FSM:
  - IDLE: if pending>0 → ISSUE; decrement pending on this transition (issue).
  - ISSUE: w=1; clear watchdog; → WAIT.
  - WAIT: watchdog increments each cycle.
    - `done`=1 → GAP; swaps_done+1.
    - Else watchdog==TIMEOUT−1 → IDLE; timeout_err=1; the request is lost, not retried.
  - GAP: one idle recovery cycle (swap unit controller returns to its rest state) → IDLE.
- Latency:
  - `req` in an idle, empty block at cycle N → w=1 at N+2.
  - `done` at cycle M → earliest next w at M+3.
- `done` outside WAIT is ignored: no count, no state change.
- `done` in the same cycle the watchdog expires: completion wins. GAP is taken, count increments, no error.
- clr_err:
  - Clears timeout_err next edge.
  - Timeout in the same cycle as clr_err: set wins.
- busy is decoded from registered state; no combinational path from req to w.

Optional Feature:
- Macro SWAP_SCHED_STATS_EN.
- Defined:
  - swaps_done is an 8-bit register.
  - Increments on each `done` accepted in WAIT; wraps 255→0.
  - Reset to 0.
- Undefined:
  - Counter logic is not instantiated; swaps_done is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Single request: rst released, req pulse at cycle 5, swap model returns done 4 cycles after w → req_ack=1 @5; w=1 @7 only; done @11; busy 0 @13; pending 0; swaps_done=1 (STATS_EN).
- Fill to full: 9 consecutive req pulses while the model stalls done → req_ack high for first 8 (1 issued + 7 pending), then 0; pending=7 held; no overflow.
- Simultaneous accept/issue: pending=1, IDLE, req asserted → pending stays 1; w pulses next cycle.
- Timeout: model never asserts done → timeout_err=1 exactly 15 cycles after WAIT entry; state IDLE; next queued request issues. Then clr_err=1 → timeout_err=0.
- Spurious and late done: done pulse in IDLE → no count change. Then done on the expiry cycle → no timeout_err; swaps_done increments.
- Async reset mid-WAIT: rst pulse asynchronously during WAIT with pending=3 → all outputs 0 immediately; no w after release until a new req.
